// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output stage: FSM encoding and default widths.
package fir_pkg;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fir_axis_out_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO with extended-MSB pointers.
module sync_fifo #(
   parameter int pWIDTH = 33,
   parameter int pDEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [pWIDTH-1:0]          din,
   input  logic                       pop,
   output logic [pWIDTH-1:0]          dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(pDEPTH):0]    level
);

   localparam int AW = $clog2(pDEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]       r_wptr;
   logic [AW:0]       r_rptr;
   logic [pWIDTH-1:0] r_mem [pDEPTH];

   // Pointer MSBs differ only when the write side has lapped the read side.
   assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign empty = (r_wptr == r_rptr);
   assign level = r_wptr - r_rptr;
   assign dout  = r_mem[r_rptr[AW-1:0]];

   // Storage and pointer update; reset wipes contents so the head reads as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         for (int i = 0; i < pDEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (push && !full) begin
            r_mem[r_wptr[AW-1:0]] <= din;
            r_wptr                <= r_wptr + PTR_ONE;
         end else begin
            r_wptr <= r_wptr;
         end
         if (pop && !empty) begin
            r_rptr <= r_rptr + PTR_ONE;
         end else begin
            r_rptr <= r_rptr;
         end
      end
   end

endmodule

// File: rtl/fir_axis_out_fifo.sv
// FIR result buffer: frame-length accounting, regenerated tlast, done and length-error reporting.
module fir_axis_out_fifo
   import fir_pkg::*;
#(
   parameter int pDATA_WIDTH = DATA_W,
   parameter int pDEPTH      = 8,
   parameter int pLEN_WIDTH  = LEN_W
) (
   input  logic                     axis_clk,
   input  logic                     axis_rst_n,
   input  logic                     cfg_start,
   input  logic [pLEN_WIDTH-1:0]    cfg_len,
   input  logic                     s_tvalid,
   input  logic [pDATA_WIDTH-1:0]   s_tdata,
   input  logic                     s_tlast,
   output logic                     s_tready,
   output logic                     m_tvalid,
   output logic [pDATA_WIDTH-1:0]   m_tdata,
   output logic                     m_tlast,
   input  logic                     m_tready,
   output logic [$clog2(pDEPTH):0]  level,
   output logic                     done,
   output logic                     len_err
);

   localparam logic [pLEN_WIDTH-1:0] LEN_ONE = pLEN_WIDTH'(1);

   state_t                  r_state;
   logic [pLEN_WIDTH-1:0]   r_len;
   logic [pLEN_WIDTH-1:0]   r_in_cnt;
   logic [pLEN_WIDTH-1:0]   r_out_cnt;
   logic                    r_len_err;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_last_pos;
   logic [pDATA_WIDTH:0]    w_head;

   assign w_last_pos = (r_in_cnt == (r_len - LEN_ONE));
   assign s_tready   = (r_state == RUN) && !w_full && (r_in_cnt < r_len);
   assign w_push     = s_tvalid && s_tready;
   assign m_tvalid   = !w_empty;
   assign w_pop      = m_tvalid && m_tready;
   assign m_tdata    = w_head[pDATA_WIDTH:1];
   assign m_tlast    = w_head[0];
   assign done       = (r_state == DONE);
   assign len_err    = r_len_err;

   sync_fifo #(
      .pWIDTH (pDATA_WIDTH + 1),
      .pDEPTH (pDEPTH)
   ) u_fifo (
      .clk   (axis_clk),
      .rst_n (axis_rst_n),
      .push  (w_push),
      .din   ({s_tdata, w_last_pos}),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

   // Frame FSM with input/output beat counters and sticky length check.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         r_state   <= IDLE;
         r_len     <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_len_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (cfg_start) begin
                  r_len     <= cfg_len;
                  r_in_cnt  <= '0;
                  r_out_cnt <= '0;
                  r_len_err <= 1'b0;
                  r_state   <= (cfg_len == '0) ? DONE : RUN;
               end else begin
                  r_state <= r_state;
               end
            end
            RUN: begin
               if (w_push) begin
                  r_in_cnt <= r_in_cnt + LEN_ONE;
                  if (s_tlast != w_last_pos) begin
                     r_len_err <= 1'b1;
                  end else begin
                     r_len_err <= r_len_err;
                  end
               end else begin
                  r_in_cnt <= r_in_cnt;
               end
               if (w_pop) begin
                  r_out_cnt <= r_out_cnt + LEN_ONE;
                  if (r_out_cnt == (r_len - LEN_ONE)) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= RUN;
                  end
               end else begin
                  r_out_cnt <= r_out_cnt;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_axis_out_fifo.sv
// Self-checking bench: hand vector table for a basic frame, then directed and random frames against a queue model.
module tb_fir_axis_out_fifo;

   localparam int DW = 32;
   localparam int LW = 32;
   localparam int D  = 8;

   logic           axis_clk = 1'b0;
   logic           axis_rst_n = 1'b0;
   logic           cfg_start = 1'b0;
   logic [LW-1:0]  cfg_len = '0;
   logic           s_tvalid = 1'b0;
   logic [DW-1:0]  s_tdata = '0;
   logic           s_tlast = 1'b0;
   logic           s_tready;
   logic           m_tvalid;
   logic [DW-1:0]  m_tdata;
   logic           m_tlast;
   logic           m_tready = 1'b0;
   logic [3:0]     level;
   logic           done;
   logic           len_err;

   fir_axis_out_fifo #(.pDATA_WIDTH(DW), .pDEPTH(D), .pLEN_WIDTH(LW)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
      .level(level), .done(done), .len_err(len_err)
   );

   always #5 axis_clk = ~axis_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: frame status plus a queue of {data, last} entries.
   bit              m_run = 1'b0;
   bit              m_done = 1'b0;
   bit              m_err = 1'b0;
   int unsigned     m_len = 0;
   int unsigned     m_in = 0;
   int unsigned     m_out = 0;
   logic [DW:0]     mq[$];

   logic [DW:0]     src[$];
   int              rmode = 0;
   int              vmode = 0;
   bit              tog = 1'b0;

   typedef struct {
      bit st; logic [31:0] ln; bit sv; logic [31:0] sd; bit sl; bit mr;
      bit e_rdy; bit e_mv; logic [31:0] e_d; bit e_l; logic [3:0] e_lvl; bit e_done; bit e_err;
   } vec_t;
   vec_t vt[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_len = 0; m_in = 0; m_out = 0;
      mq.delete();
   endtask

   // Called at a negedge: compare outputs with the model, drive inputs, advance one clock.
   task automatic tick(input bit st, input logic [LW-1:0] ln, input bit sv, input logic [DW-1:0] sd,
                       input bit sl, input bit mr, output bit psh);
      bit e_rdy, e_mv, pp, lastpos, was_run;
      was_run = m_run;
      e_rdy = m_run && (mq.size() < D) && (m_in < m_len);
      e_mv  = (mq.size() > 0);
      chk("s_tready", s_tready, e_rdy);
      chk("m_tvalid", m_tvalid, e_mv);
      chk("level", level, mq.size());
      chk("done", done, m_done);
      chk("len_err", len_err, m_err);
      if (e_mv) begin
         chk("m_tdata", m_tdata, mq[0][DW:1]);
         chk("m_tlast", m_tlast, mq[0][0]);
      end
      cfg_start = st; cfg_len = ln; s_tvalid = sv; s_tdata = sd; s_tlast = sl; m_tready = mr;
      psh = sv && e_rdy;
      pp  = e_mv && mr;
      if (pp) begin
         void'(mq.pop_front());
         m_out++;
         if (m_run && m_out == m_len) begin
            m_run = 1'b0; m_done = 1'b1;
         end
      end
      if (psh) begin
         lastpos = (m_in == m_len - 1);
         mq.push_back({sd, lastpos});
         if (sl != lastpos) m_err = 1'b1;
         m_in++;
      end
      if (st && !was_run) begin
         m_len = ln; m_in = 0; m_out = 0; m_err = 1'b0;
         m_run = (ln != 0); m_done = (ln == 0);
      end
      @(posedge axis_clk);
      @(negedge axis_clk);
   endtask

   task automatic step(input bit st, input logic [LW-1:0] ln);
      bit sv, sl, mr, psh;
      logic [DW-1:0] sd;
      sv = (src.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
      if (src.size() > 0) begin
         sd = src[0][DW:1]; sl = src[0][0];
      end else begin
         sd = $urandom; sl = 1'b0;
      end
      tog = ~tog;
      case (rmode)
         0: mr = 1'b1;
         1: mr = 1'b0;
         2: mr = tog;
         default: mr = ($urandom_range(0, 1) == 1);
      endcase
      tick(st, ln, sv, sd, sl, mr, psh);
      if (psh) void'(src.pop_front());
   endtask

   task automatic run_until_done(input int maxc);
      int n = 0;
      while (!m_done && n < maxc) begin
         step(1'b0, '0);
         n++;
      end
      chk("done_within_budget", done, 1'b1);
   endtask

   task automatic load_src(input int n, input logic [DW-1:0] base, input int last_at);
      for (int i = 0; i < n; i++) begin
         src.push_back({base + DW'(i), (i == last_at)});
      end
   endtask

   initial begin
      logic [DW-1:0] held;
      bit            dummy;

      vt[0] = '{1'b1, 32'd5, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0};
      vt[2] = '{1'b0, 32'd0, 1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 4'd1, 1'b0, 1'b0};
      vt[3] = '{1'b0, 32'd0, 1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 4'd1, 1'b0, 1'b0};
      vt[4] = '{1'b0, 32'd0, 1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 1'b0, 4'd1, 1'b0, 1'b0};
      vt[5] = '{1'b0, 32'd0, 1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 4'd1, 1'b0, 1'b0};
      vt[6] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd5, 1'b1, 4'd1, 1'b0, 1'b0};
      vt[7] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0};

      // Reset values.
      repeat (2) @(negedge axis_clk);
      chk("rst_s_tready", s_tready, 1'b0);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_m_tdata", m_tdata, 32'd0);
      chk("rst_m_tlast", m_tlast, 1'b0);
      chk("rst_level", level, 4'd0);
      chk("rst_done", done, 1'b0);
      chk("rst_len_err", len_err, 1'b0);
      axis_rst_n = 1'b1;

      // Basic five-beat frame from the vector table.
      for (int i = 0; i < 8; i++) begin
         chk("vec_s_tready", s_tready, vt[i].e_rdy);
         chk("vec_m_tvalid", m_tvalid, vt[i].e_mv);
         if (vt[i].e_mv) begin
            chk("vec_m_tdata", m_tdata, vt[i].e_d);
            chk("vec_m_tlast", m_tlast, vt[i].e_l);
         end
         chk("vec_level", level, vt[i].e_lvl);
         chk("vec_done", done, vt[i].e_done);
         chk("vec_len_err", len_err, vt[i].e_err);
         tick(vt[i].st, vt[i].ln, vt[i].sv, vt[i].sd, vt[i].sl, vt[i].mr, dummy);
      end

      // Backpressure fills the FIFO, then drains in order.
      rmode = 1; vmode = 0;
      load_src(12, 32'h100, 11);
      step(1'b1, 32'd12);
      repeat (11) step(1'b0, '0);
      chk("t2_full_level", level, 4'd8);
      chk("t2_full_ready", s_tready, 1'b0);
      held = m_tdata;
      step(1'b0, '0);
      chk("t2_stall_hold", m_tdata, held);
      rmode = 0;
      run_until_done(60);

      // Early s_tlast flags an error; m_tlast still on the programmed last beat.
      src.delete();
      load_src(4, 32'h200, 2);
      step(1'b1, 32'd4);
      run_until_done(30);
      chk("t3_len_err_set", len_err, 1'b1);
      step(1'b1, 32'd0);
      chk("t3_len_err_clear", len_err, 1'b0);

      // Surplus beat is held off and becomes the next frame's only beat.
      src.delete();
      src.push_back({32'h301, 1'b0});
      src.push_back({32'h302, 1'b0});
      src.push_back({32'h303, 1'b1});
      src.push_back({32'h304, 1'b1});
      step(1'b1, 32'd3);
      run_until_done(30);
      repeat (3) step(1'b0, '0);
      chk("t4_surplus_held", s_tready, 1'b0);
      step(1'b1, 32'd1);
      run_until_done(20);
      chk("t4_len_err", len_err, 1'b0);

      // Toggling consumer with continuous producer; a start mid-frame is ignored.
      src.delete();
      for (int i = 0; i < 20; i++) src.push_back({DW'($urandom), (i == 19)});
      rmode = 2;
      step(1'b1, 32'd20);
      repeat (4) step(1'b0, '0);
      step(1'b1, 32'd7);
      run_until_done(120);

      // Random frames with random handshakes and occasional wrong or surplus beats.
      rmode = 3; vmode = 1;
      for (int f = 0; f < 30; f++) begin
         int n, la, extra;
         src.delete();
         n = $urandom_range(0, 20);
         la = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : n - 1;
         extra = ($urandom_range(0, 4) == 0) ? 1 : 0;
         for (int i = 0; i < n + extra; i++) src.push_back({DW'($urandom), (i == la)});
         step(1'b1, LW'(n));
         run_until_done(200);
         repeat ($urandom_range(0, 2)) step(1'b0, '0);
      end

      // Asynchronous reset mid-frame with five entries buffered.
      src.delete();
      rmode = 1; vmode = 0;
      load_src(10, 32'h600, 9);
      step(1'b1, 32'd10);
      repeat (5) step(1'b0, '0);
      chk("t6_level_before", level, 4'd5);
      axis_rst_n = 1'b0;
      #1;
      chk("t6_m_tvalid", m_tvalid, 1'b0);
      chk("t6_level", level, 4'd0);
      chk("t6_s_tready", s_tready, 1'b0);
      chk("t6_done", done, 1'b0);
      model_reset();
      src.delete();
      @(negedge axis_clk);
      axis_rst_n = 1'b1;
      rmode = 0;
      load_src(2, 32'h700, 1);
      repeat (3) step(1'b0, '0);
      step(1'b1, 32'd2);
      run_until_done(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_axis_out_fifo.md
Name: fir_axis_out_fifo

Overview:
- Downstream stage of the FIR core. Buffers the FIR result AXI-Stream (sm_*) in a small synchronous FIFO, absorbing backpressure from the consumer (DMA / testbench sink).
- Counts delivered samples against the programmed data length and regenerates a clean m_tlast on the final beat.
- Reports done, level and a sticky length-mismatch error.

Parameters:
- pDATA_WIDTH, 32, stream data width
- pDEPTH, 8, FIFO entries; must be a power of 2, minimum 2
- pLEN_WIDTH, 32, width of the length and sample counters

Ports:
- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse; arms a new frame
- cfg_len  in  pLEN_WIDTH  samples per frame; sampled on cfg_start
- s_tvalid  in  1  input valid (from FIR sm_tvalid)
- s_tdata  in  pDATA_WIDTH  input data
- s_tlast  in  1  input last flag
- s_tready  out  1  input ready
- m_tvalid  out  1  output valid
- m_tdata  out  pDATA_WIDTH  output data
- m_tlast  out  1  output last (regenerated)
- m_tready  in  1  output ready
- level  out  $clog2(pDEPTH)+1  current occupancy
- done  out  1  frame fully delivered; held until next cfg_start
- len_err  out  1  sticky: s_tlast position disagreed with cfg_len

Behaviour:
- Reset state (async): state=IDLE, FIFO empty, all counters 0.
  - Outputs: s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, level=0, done=0, len_err=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on cfg_start. Latches len_r=cfg_len and clears in_cnt, out_cnt, len_err, done.
  - RUN -> DONE on the output handshake (m_tvalid & m_tready) where out_cnt==len_r-1.
  - DONE -> RUN on cfg_start (same latch/clear as above).
  - cfg_start in RUN is ignored.
  - cfg_start with cfg_len==0 goes directly to DONE with done=1.
- Push:
  - s_tready = (state==RUN) & ~full & (in_cnt < len_r).
  - A push occurs when s_tvalid & s_tready; in_cnt increments on each push.
  - Beats beyond len_r are not accepted; s_tready stays 0 until the next cfg_start.
- Pop:
  - First-word fall-through: m_tvalid = ~empty, and m_tdata is the head entry, combinationally from the storage array.
  - m_tdata, m_tlast and m_tvalid are stable while m_tvalid & ~m_tready (AXI-Stream rule).
  - out_cnt increments on each handshake.
- Full/empty:
  - Write pointer and read pointer are each $clog2(pDEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - Simultaneous push and pop when not full and not empty: level unchanged, both pointers advance.
  - When full, s_tready=0 in that cycle even if a pop occurs; there is no same-cycle pass-through.
  - When empty, a push becomes visible on m_tvalid the next cycle (1-cycle latency).
- m_tlast:
  - Stored per entry and set at push time when in_cnt==len_r-1.
  - s_tlast is not forwarded.
- len_err:
  - Set when a push has s_tlast=1 and in_cnt!=len_r-1.
  - Set when a push has s_tlast=0 and in_cnt==len_r-1.
  - Sticky until cfg_start or reset.
- Width rules:
  - Counters are pLEN_WIDTH bits and compare unsigned.
  - Data passes through unmodified.
- done: a registered 1 in the cycle after the last output handshake, i.e. in state DONE.
- Reset mid-frame: FIFO contents are discarded, pointers cleared, and the block returns to IDLE.

Decomposition:
- Shared package fir_pkg:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default widths: DATA_W=32, LEN_W=32
- Sub-module sync_fifo:
  - Parameters: width = pDATA_WIDTH+1 (data+last), depth = pDEPTH.
  - Ports: push, pop, full, empty, level.
- The parent holds the FSM, counters and error logic.

Test Plan:
1. cfg_start with cfg_len=5; push 5 beats 0x1..0x5 with s_tlast on the 5th; m_tready=1 throughout -> outputs 0x1..0x5, m_tlast only on 0x5, done=1 the cycle after, len_err=0.
2. cfg_len=12, pDEPTH=8, m_tready=0 -> after 8 pushes s_tready=0 and level=8. Then raise m_tready -> all 12 beats delivered in order with m_tdata stable while stalled, done=1.
3. cfg_len=4 with s_tlast on the 3rd beat -> len_err=1 after that push; m_tlast still on the 4th beat; len_err clears on the next cfg_start.
4. cfg_len=3 and 4 beats offered -> only 3 accepted, the 4th is held with s_tready=0. Then cfg_start with cfg_len=1 -> the 4th beat is accepted as the new frame's last, with m_tlast=1.
5. Toggle m_tready every cycle with continuous s_tvalid, cfg_len=20 -> no data loss or duplication, level never exceeds 8, output sequence matches input.
6. Assert axis_rst_n=0 mid-frame with level=5 -> next cycle m_tvalid=0, level=0, s_tready=0, state IDLE.
